adc_frame_capture: RTL and testbench
====================================

// Module: adc_frame_capture
// PURPOSE
//  Consumes the 12-bit offset-binary samples from the ADC capture stage (one per clk).
//  On a start pulse it converts each sample to two's complement and decimates by decim+1.
//  It stores DEPTH samples in a frame RAM, then streams the frame out over valid/ready.
//  The stream feeds the FFT / harmonic-analysis path for distortion measurement.
// PARAMETERS
//  DATA_W   12    sample width (ADC and output)
//  DEPTH    1024  samples per frame; power of two, >= 4
//  ADDR_W   10    log2(DEPTH)
//  DECIM_W  8     width of decimation control
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  adc_data   in   DATA_W   offset-binary sample from ADC capture stage, new value every clk
//  decim      in   DECIM_W  keep 1 of every decim+1 samples; latched on accepted start
//  start      in   1        1-cycle request to capture a frame; honoured only in IDLE
//  busy       out  1        high from cycle after accepted start until last output beat done
//  done       out  1        1-cycle pulse: frame fully written, readout begins
//  out_data   out  DATA_W   signed sample (two's complement)
//  out_valid  out  1        out_data valid
//  out_ready  in   1        downstream accepts; beat transfers when out_valid && out_ready
//  out_last   out  1        high with final (index DEPTH-1) beat of frame
// BEHAVIOUR
//  Interface: one clock clk, synchronous active-high reset rst.
//  Reset: state=IDLE; busy, done, out_valid, out_last = 0; out_data = 0; all counters 0.
//  Reset mid-capture/readout: IDLE on next edge, no partial output; RAM contents undefined.
//  Conversion: s = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]}. 0x000->-2048, 0x800->0, 0xFFF->+2047.
//  FSM IDLE -> CAPTURE -> READOUT -> IDLE
//   IDLE: start=1 -> decim_q<=decim, wr_addr<=0, dec_cnt<=0; go CAPTURE.
//   CAPTURE: write when dec_cnt==0, sampling adc_data of that cycle; wr_addr++ on write.
//     dec_cnt <= (dec_cnt==decim_q) ? 0 : dec_cnt+1.
//     The first CAPTURE cycle is a write. decim=0: every sample. decim=255: every 256th.
//     After write at wr_addr=DEPTH-1: go READOUT; done=1 for exactly that next cycle.
//   READOUT: RAM read latency 1 clk; 2-entry prefetch/skid so backpressure never drops beats.
//     out_valid rises no later than 2 clks after entering READOUT.
//     out_ready held 1 -> one beat per clk sustained; DEPTH beats in <= DEPTH+2 clks.
//     While out_valid && !out_ready: out_data and out_last held stable.
//     out_last=1 only on index DEPTH-1.
//     After last beat transfers: out_valid=0, busy=0, go IDLE the same edge.
//  start outside IDLE (incl. cycle of last transfer) ignored; decim changes ignored until next start.
//  Frame indices wrap nowhere: exactly DEPTH writes and DEPTH reads per start.
// STRUCTURE
//  Package adc_cap_pkg: DATA_W, state encoding (IDLE/CAPTURE/READOUT), offset-to-signed function.
//  Sub-module frame_ram: simple dual-port RAM, DATA_W x DEPTH.
//   Sync write port, sync read port with 1-clk latency, no reset.
//   Infers block RAM.
//  Top holds FSM, decimation counter, address counters, readout prefetch/skid.
// TESTING (DEPTH=16 override unless stated)
//  1 Reset: rst 2 clks mid-CAPTURE and mid-READOUT -> next clk busy=0, out_valid=0.
//    Then a new start gives a clean full frame.
//  2 Ramp adc 0x7F8.. +1/clk, decim=0, out_ready=1 -> 16 beats -8..+7, out_last on 16th.
//    done one pulse; busy low after last beat.
//  3 Ramp from 0x000, decim=3 -> beats -2048,-2044,...,-1988 (every 4th); decim=255 -> stride 256.
//  4 Random out_ready (50%) over 3 frames -> scoreboard: no lost/duplicated beats.
//    out_data/out_last stable during stalls.
//  5 start pulsed during CAPTURE, READOUT and on last-transfer cycle -> ignored.
//    decim toggled mid-frame -> no effect.
//  6 Throughput, DEPTH=1024: out_ready=1 -> 1024 beats within 1026 clks of done.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC frame capture block: sample width, FSM states
// and the offset-binary to two's-complement conversion.
package adc_cap_pkg;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      READOUT = 2'd2
   } state_t;

   // Flipping the MSB maps mid-scale 0x800 to zero.
   function automatic logic [DATA_W-1:0] offset_to_signed(input logic [DATA_W-1:0] raw);
      return {~raw[DATA_W-1], raw[DATA_W-2:0]};
   endfunction
endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read (1-clk latency).
module frame_ram #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              re,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/adc_frame_capture.sv
// Captures one decimated frame of ADC samples into a frame RAM, then streams it
// out over valid/ready through a 2-entry prefetch so backpressure never loses beats.
module adc_frame_capture #(
   parameter int DATA_W  = 12,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10,
   parameter int DECIM_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  adc_data,
   input  logic [DECIM_W-1:0] decim,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last
);
   import adc_cap_pkg::*;

   state_t             state;
   logic [DECIM_W-1:0] decim_q, dec_cnt;
   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W:0]    rd_cnt;
   logic [DATA_W-1:0]  ram_q, skid_data;
   logic               rd_vld_p1, rd_last_p1;
   logic               skid_vld, skid_last;
   logic               we, rd_en, pop;
   logic [2:0]         occ;

   assign we    = (state == CAPTURE) && (dec_cnt == '0);
   assign pop   = out_valid && out_ready;
   // Output reg + skid reg + read in flight must never exceed two entries.
   assign occ   = 3'(out_valid) + 3'(skid_vld) + 3'(rd_vld_p1);
   assign rd_en = (state == READOUT) && !rd_cnt[ADDR_W] && (occ <= 3'd1 + 3'(pop));

   frame_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (offset_to_signed(adc_data)),
      .re      (rd_en),
      .rd_addr (rd_cnt[ADDR_W-1:0]),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         decim_q    <= '0;
         dec_cnt    <= '0;
         wr_addr    <= '0;
         rd_cnt     <= '0;
         rd_vld_p1  <= 1'b0;
         rd_last_p1 <= 1'b0;
         skid_vld   <= 1'b0;
         skid_last  <= 1'b0;
         skid_data  <= '0;
      end else begin
         done       <= 1'b0;
         // RAM read stage: tags travel one clock behind the read request.
         rd_vld_p1  <= rd_en;
         rd_last_p1 <= rd_en && (rd_cnt[ADDR_W-1:0] == '1);
         if (rd_en) rd_cnt <= rd_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  decim_q <= decim;
                  wr_addr <= '0;
                  dec_cnt <= '0;
                  rd_cnt  <= '0;
                  busy    <= 1'b1;
                  state   <= CAPTURE;
               end
            end
            CAPTURE: begin
               dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + 1'b1;
               if (we) begin
                  wr_addr <= wr_addr + 1'b1;
                  if (wr_addr == '1) begin
                     state <= READOUT;
                     done  <= 1'b1;
                  end
               end
            end
            READOUT: begin
               if (pop) begin
                  if (skid_vld) begin
                     out_data <= skid_data;
                     out_last <= skid_last;
                     if (rd_vld_p1) begin
                        skid_data <= ram_q;
                        skid_last <= rd_last_p1;
                     end else begin
                        skid_vld <= 1'b0;
                     end
                  end else if (rd_vld_p1) begin
                     out_data <= ram_q;
                     out_last <= rd_last_p1;
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end
               end else if (rd_vld_p1) begin
                  if (!out_valid) begin
                     out_valid <= 1'b1;
                     out_data  <= ram_q;
                     out_last  <= rd_last_p1;
                  end else begin
                     skid_vld  <= 1'b1;
                     skid_data <= ram_q;
                     skid_last <= rd_last_p1;
                  end
               end
               if (pop && out_last) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_frame_capture.sv
// Scoreboard bench for adc_frame_capture: a 16-deep instance for function and
// reset behaviour, and a 1024-deep instance for sustained throughput.
module tb_adc_frame_capture;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] adc_data = '0;
   logic [7:0]  decim = '0;
   logic        start = 1'b0;
   logic        busy, done, out_valid, out_last;
   logic [11:0] out_data;
   logic        out_ready = 1'b0;

   logic [11:0] adc2 = 12'hABC;
   logic [7:0]  decim2 = '0;
   logic        start2 = 1'b0;
   logic        ready2 = 1'b1;
   logic        busy2, done2, out_valid2, out_last2;
   logic [11:0] out_data2;

   int          passed = 0;
   int          total = 0;
   int          done_cnt = 0;
   int          ready_mode = 0;
   int          exp_d[$];
   bit          exp_l[$];
   int          ed;
   bit          el;
   bit          stalled_prev = 1'b0;
   logic [11:0] hold_d = '0;
   logic        hold_l = 1'b0;

   always #5 clk = ~clk;

   adc_frame_capture #(.DATA_W(12), .DEPTH(16), .ADDR_W(4), .DECIM_W(8)) dut (
      .clk(clk), .rst(rst), .adc_data(adc_data), .decim(decim), .start(start),
      .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last)
   );

   adc_frame_capture #(.DATA_W(12), .DEPTH(1024), .ADDR_W(10), .DECIM_W(8)) dut2 (
      .clk(clk), .rst(rst), .adc_data(adc2), .decim(decim2), .start(start2),
      .busy(busy2), .done(done2), .out_data(out_data2), .out_valid(out_valid2),
      .out_ready(ready2), .out_last(out_last2)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, req);
   endtask

   // out_ready driver: 0 = always ready, 1 = random 50%, 2 = never ready
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 1) == 1);
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on every transfer and checks stall stability.
   always @(negedge clk) begin
      if (out_valid && out_ready && !rst) begin
         total++;
         if (exp_d.size() == 0) begin
            $display("FAIL unexpected_beat actual=%0d last=%0b required=none", $signed(out_data), out_last);
         end else begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            if ($signed(out_data) == ed && out_last == el) passed++;
            else $display("FAIL beat actual=%0d/last%0b required=%0d/last%0b",
                          $signed(out_data), out_last, ed, el);
         end
      end
      if (stalled_prev && !rst) begin
         total++;
         if (out_valid && out_data == hold_d && out_last == hold_l) passed++;
         else $display("FAIL stall_hold actual=%0d/v%0b/last%0b required=%0d/v1/last%0b",
                       $signed(out_data), out_valid, out_last, $signed(hold_d), hold_l);
      end
      stalled_prev = out_valid && !out_ready && !rst;
      hold_d = out_data;
      hold_l = out_last;
      if (done) done_cnt++;
   end

   // Ramp capture: adc_data = base+k in the k-th CAPTURE cycle, so beat i
   // carries (base + i*(d+1)) mod 4096 shifted down by 2048.
   task automatic run_frame(input int base, input int d, input bit poke);
      int timeout;
      for (int i = 0; i < 16; i++) begin
         exp_d.push_back(((base + i * (d + 1)) % 4096) - 2048);
         exp_l.push_back(i == 15);
      end
      done_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1;
      decim = d[7:0];
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k <= 15 * (d + 1); k++) begin
         adc_data = 12'(base + k);
         if (poke && k == 3) begin
            start = 1'b1;
            decim = ~decim;
         end
         if (poke && k == 4) start = 1'b0;
         @(posedge clk); #1;
      end
      decim = d[7:0];
      timeout = 1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke && c == 2) start = 1'b1;
         if (poke && out_valid && out_last && out_ready) start = 1'b1;
         if (!busy) begin
            timeout = 0;
            break;
         end
      end
      start = 1'b0;
      check("frame_end_timeout", timeout, 0);
      check("done_pulses", done_cnt, 1);
      check("queue_drained", exp_d.size(), 0);
      check("valid_after_last", int'(out_valid), 0);
      if (poke) begin
         repeat (3) @(negedge clk);
         check("start_ignored_busy", int'(busy), 0);
      end
      exp_d.delete();
      exp_l.delete();
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(out_valid), 0);
   endtask

   initial begin
      int timeout, beats, bad, last_c;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_last", int'(out_last), 0);
      check("reset_data", int'(out_data), 0);

      // reset during capture
      ready_mode = 0;
      @(posedge clk); #1;
      start = 1'b1;
      decim = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      pulse_reset();

      // reset during a stalled readout
      ready_mode = 2;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      timeout = 1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (out_valid) begin
            timeout = 0;
            break;
         end
      end
      check("readout_valid_timeout", timeout, 0);
      pulse_reset();
      ready_mode = 0;
      run_frame(12'h7F8, 0, 1'b0);

      run_frame(12'h000, 3, 1'b0);
      run_frame(12'h000, 255, 1'b0);

      ready_mode = 1;
      run_frame(12'h123, 0, 1'b0);
      run_frame(12'hF00, 1, 1'b0);
      run_frame(12'h555, 2, 1'b1);

      ready_mode = 0;
      run_frame(12'hA00, 1, 1'b1);

      // sustained throughput on the full-depth instance
      @(posedge clk); #1;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      timeout = 1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (done2) begin
            timeout = 0;
            break;
         end
      end
      check("done2_timeout", timeout, 0);
      beats = 0;
      bad = 0;
      last_c = 0;
      for (int c = 1; c <= 1100; c++) begin
         if (c > 1) @(negedge clk);
         if (out_valid2) begin
            beats++;
            if ($signed(out_data2) != 700) bad++;
            if (out_last2) begin
               last_c = c;
               break;
            end
         end
      end
      check("tput_beats", beats, 1024);
      check("tput_bad_data", bad, 0);
      check("tput_last_within_1026", int'(last_c > 0 && last_c <= 1026), 1);
      @(negedge clk);
      check("tput_busy_end", int'(busy2), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
